peak_bin_finder: RTL and testbench
==================================

Name: peak_bin_finder

Overview:
- Upstream stage of the beamforming weight/DOA block.
- After the FFT of microphone channel 1 completes, it scans FFT RAM 1 over a configurable bin range and computes |X|^2 for each bin.
- It reports the bin with maximum power as maxbin and pulses detectdone.
- It then holds rdaddr1 at maxbin so the downstream block reads channel 1 at that bin.

Parameters:
- BIN_W, 10, bin address width (1024-point FFT).
- BIN_LO, 1, first scanned bin (skips DC).
- BIN_HI, 511, last scanned bin, inclusive (positive frequencies). Requires BIN_LO <= BIN_HI.
- RD_LAT, 1, FFT RAM read latency in cycles. Only 1 or 2 are legal.
- PWR_MIN, 0, minimum peak power (28-bit unsigned) needed to declare a detection.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- fftdone  in  1  one-cycle pulse: FFT RAM 1 contents valid, start a scan
- ramq1  in  28  FFT RAM 1 read data; [27:14] real, [13:0] imag, both signed two's complement
- rdaddr1  out  BIN_W  FFT RAM 1 read address
- maxbin  out  BIN_W  bin index of peak power
- maxpwr  out  28  peak power re^2+im^2, unsigned
- detectdone  out  1  one-cycle pulse: maxbin/maxpwr valid, peak found
- miss  out  1  one-cycle pulse: scan finished but maxpwr < PWR_MIN
- busy  out  1  high in SCAN and DRAIN

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: rdaddr1=0, maxbin=0, maxpwr=0, detectdone=0, miss=0, busy=0, state=IDLE. Reset mid-scan aborts with no pulse.
- States:
  - IDLE: on fftdone, go to SCAN. Clear the running max and max bin; rdaddr1 <= BIN_LO.
  - SCAN: rdaddr1 increments by 1 each cycle. One address is issued per cycle, BIN_LO..BIN_HI inclusive. When rdaddr1==BIN_HI, go to DRAIN.
  - DRAIN: wait RD_LAT+1 cycles for the in-flight bins to pass through compare.
  - Exit from DRAIN:
    - If maxpwr >= PWR_MIN: pulse detectdone, set rdaddr1 <= maxbin, go to COMPLETE.
    - Otherwise: pulse miss, set rdaddr1 <= 0, go to IDLE.
  - COMPLETE: rdaddr1, maxbin and maxpwr are held stable. fftdone starts a new scan, same as from IDLE.
- Pipeline:
  - Address issued in cycle c yields ramq1 valid in cycle c+RD_LAT.
  - re^2 and im^2 are registered at c+RD_LAT+1.
  - The compare/update uses the registered sum.
  - A valid bit plus the bin index travel alongside the data.
- Arithmetic:
  - re and im are sign-extended; each square is 27-bit unsigned, the sum is 28-bit unsigned.
  - Max case: re=im=-8192 gives 2^27 = 134217728. No overflow is possible.
- Compare is strict greater-than. On ties the lowest bin wins.
  - The first valid bin always loads, even if its power is 0, so an all-zero spectrum gives maxbin=BIN_LO, maxpwr=0.
- Latency: detectdone or miss is high exactly N+RD_LAT+2 cycles after the edge that samples fftdone, where N=BIN_HI-BIN_LO+1. With defaults this is 514.
- fftdone while busy=1 is ignored; the scan is not restarted.
- maxbin/maxpwr change only at detectdone/miss. Internal running max registers are separate, so the outputs never show partial results.
- detectdone and miss are never high simultaneously, and each lasts exactly one cycle.
- Bins outside [BIN_LO, BIN_HI] are never read and never influence the result.

Decomposition:
- Shared package fft_pkg holds:
  - BIN_W=10, SAMPLE_W=14.
  - typedef cbin_t: packed struct {logic signed [13:0] re; logic signed [13:0] im;}. Its layout matches the 28-bit RAM word.
  - typedef pwr_t = logic [27:0].
  - The state enum.
- Sub-module cmag_sq: registered magnitude-squared of a cbin_t, 1-cycle latency, with a valid/tag passthrough. It is reusable by other stages.

Test Plan:
- Single tone: RAM all 0 except bin 100 = (re 1000, im -500), fftdone → detectdone at cycle 514, maxbin=100, maxpwr=1250000, rdaddr1 held at 100 in COMPLETE.
- Tie and range:
  - Bins 40 and 300 both (300,400), bin 600 = (8191,0) → maxbin=40, maxpwr=250000.
  - Bin 600 is ignored because it is outside the range.
- Extremes and threshold:
  - Bin 7 = (-8192,-8192) → maxpwr=134217728, maxbin=7.
  - With PWR_MIN=1 and RAM all 0 → miss pulse only, no detectdone, state IDLE, maxbin=1, maxpwr=0.
- Restart and ignore:
  - fftdone again at cycle 200 of a scan → ignored; result still at cycle 514.
  - fftdone in COMPLETE with new data (bin 250 peak) → maxbin=250 after a further 514 cycles.
- Reset mid-scan: assert reset at cycle 300 → all outputs 0 next cycle, no detectdone. A following fftdone gives a correct full scan.
- RD_LAT=2 build: single tone at bin 511 → maxbin=511, detectdone at cycle 515.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT-domain types: complex bin word layout, power type and the
// peak-finder state encoding.
package fft_pkg;

    localparam int BIN_W    = 10;
    localparam int SAMPLE_W = 14;
    localparam int PWR_W    = 2 * SAMPLE_W;

    // Matches the 28-bit FFT RAM word: real part in the upper half.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cbin_t;

    // re^2 + im^2 fits in 28 bits unsigned (max 2^27).
    typedef logic [PWR_W-1:0] pwr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_COMPLETE
    } state_t;

endpackage

// File: rtl/peak_bin_finder_if.sv
// Bus between the FFT RAM / downstream stage and the peak-bin finder.
// master: upstream/downstream side; slave: the peak-bin finder itself.
interface peak_bin_finder_if #(
    parameter int BIN_W = 10
) ();
    import fft_pkg::*;

    logic             fftdone;
    logic [27:0]      ramq1;
    logic [BIN_W-1:0] rdaddr1;
    logic [BIN_W-1:0] maxbin;
    pwr_t             maxpwr;
    logic             detectdone;
    logic             miss;
    logic             busy;

    modport master (
        output fftdone,
        output ramq1,
        input  rdaddr1,
        input  maxbin,
        input  maxpwr,
        input  detectdone,
        input  miss,
        input  busy
    );

    modport slave (
        input  fftdone,
        input  ramq1,
        output rdaddr1,
        output maxbin,
        output maxpwr,
        output detectdone,
        output miss,
        output busy
    );

endinterface

// File: rtl/cmag_sq.sv
// Registered magnitude-squared of one complex FFT bin, one cycle of latency.
// A valid bit and an opaque tag travel with the data so callers can keep
// bin indices aligned with the power value.
module cmag_sq
    import fft_pkg::*;
#(
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_vld,
    input  logic [TAG_W-1:0] i_tag,
    input  cbin_t            i_cbin,
    output logic             o_vld,
    output logic [TAG_W-1:0] o_tag,
    output pwr_t             o_pwr
);

    // Sign-extend before squaring so the full product width is computed.
    logic signed [PWR_W-1:0] w_re_ext;
    logic signed [PWR_W-1:0] w_im_ext;
    logic signed [PWR_W-1:0] w_re_sq;
    logic signed [PWR_W-1:0] w_im_sq;

    pwr_t             r_re_sq;
    pwr_t             r_im_sq;
    logic             r_vld;
    logic [TAG_W-1:0] r_tag;

    assign w_re_ext = PWR_W'(i_cbin.re);
    assign w_im_ext = PWR_W'(i_cbin.im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    // Register both squares together with the valid bit and tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_vld   <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_re_sq <= pwr_t'(w_re_sq);
            r_im_sq <= pwr_t'(w_im_sq);
            r_vld   <= i_vld;
            r_tag   <= i_tag;
        end
    end

    // Each square is at most 2^26, so the 28-bit sum cannot overflow.
    assign o_pwr = r_re_sq + r_im_sq;
    assign o_vld = r_vld;
    assign o_tag = r_tag;

endmodule

// File: rtl/peak_bin_finder.sv
// Scans FFT RAM 1 over [BIN_LO, BIN_HI] after each fftdone, finds the bin
// with maximum |X|^2 (lowest bin wins ties) and then parks rdaddr1 on that
// bin for the downstream stage. RD_LAT must be 1 or 2 and BIN_LO <= BIN_HI.
module peak_bin_finder #(
    parameter int          BIN_W   = 10,
    parameter int          BIN_LO  = 1,
    parameter int          BIN_HI  = 511,
    parameter int          RD_LAT  = 1,
    parameter int unsigned PWR_MIN = 0
) (
    input logic              clk,
    input logic              reset,
    peak_bin_finder_if.slave bus
);
    import fft_pkg::*;

    // Cycles spent in DRAIN so the last bin's compare lands before the exit
    // decision; gives detectdone/miss at N+RD_LAT+2 cycles after fftdone.
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT + 1);

    state_t           r_state;
    logic [BIN_W-1:0] r_rdaddr1;
    logic [BIN_W-1:0] r_maxbin;
    pwr_t             r_maxpwr;
    logic             r_detectdone;
    logic             r_miss;
    logic             r_busy;
    logic [1:0]       r_drain_cnt;

    // Running maximum, kept apart from the outputs so partial results
    // never become visible.
    logic [BIN_W-1:0] r_run_bin;
    pwr_t             r_run_pwr;
    logic             r_run_loaded;

    // Valid/bin tags following the RAM read latency.
    logic             r_dly_vld [RD_LAT];
    logic [BIN_W-1:0] r_dly_bin [RD_LAT];

    logic             w_start;
    logic             w_issue_vld;
    logic             w_pass;
    logic             w_mag_vld;
    logic [BIN_W-1:0] w_mag_bin;
    pwr_t             w_mag_pwr;

    // fftdone is honoured only when no scan is in progress.
    assign w_start     = bus.fftdone && (r_state == ST_IDLE || r_state == ST_COMPLETE);
    // The address on rdaddr1 is a real bin read exactly while in SCAN.
    assign w_issue_vld = (r_state == ST_SCAN);

    // A zero threshold always passes; skip the comparison entirely.
    if (PWR_MIN == 0) begin : g_no_min
        assign w_pass = 1'b1;
    end else begin : g_min
        assign w_pass = (r_run_pwr >= pwr_t'(PWR_MIN));
    end

    // Delay the issue-valid and bin index to line up with ramq1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_dly_vld[i] <= 1'b0;
                r_dly_bin[i] <= '0;
            end
        end else begin
            r_dly_vld[0] <= w_issue_vld;
            r_dly_bin[0] <= r_rdaddr1;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dly_vld[i] <= r_dly_vld[i-1];
                r_dly_bin[i] <= r_dly_bin[i-1];
            end
        end
    end

    cmag_sq #(
        .TAG_W (BIN_W)
    ) u_cmag_sq (
        .clk    (clk),
        .reset  (reset),
        .i_vld  (r_dly_vld[RD_LAT-1]),
        .i_tag  (r_dly_bin[RD_LAT-1]),
        .i_cbin (cbin_t'(bus.ramq1)),
        .o_vld  (w_mag_vld),
        .o_tag  (w_mag_bin),
        .o_pwr  (w_mag_pwr)
    );

    // Track the running max: first valid bin always loads, later bins
    // only on strictly greater power so the lowest bin wins ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_bin    <= '0;
            r_run_pwr    <= '0;
            r_run_loaded <= 1'b0;
        end else if (w_start) begin
            r_run_bin    <= BIN_W'(BIN_LO);
            r_run_pwr    <= '0;
            r_run_loaded <= 1'b0;
        end else if (w_mag_vld && (!r_run_loaded || (w_mag_pwr > r_run_pwr))) begin
            r_run_bin    <= w_mag_bin;
            r_run_pwr    <= w_mag_pwr;
            r_run_loaded <= 1'b1;
        end
    end

    // Scan control FSM with registered address, result and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rdaddr1    <= '0;
            r_maxbin     <= '0;
            r_maxpwr     <= '0;
            r_detectdone <= 1'b0;
            r_miss       <= 1'b0;
            r_busy       <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            r_detectdone <= 1'b0;
            r_miss       <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COMPLETE: begin
                    if (bus.fftdone) begin
                        r_state   <= ST_SCAN;
                        r_rdaddr1 <= BIN_W'(BIN_LO);
                        r_busy    <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Last address stays on the bus; it is not re-issued
                    // because issue-valid drops with the state change.
                    if (r_rdaddr1 == BIN_W'(BIN_HI)) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_rdaddr1 <= r_rdaddr1 + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_busy   <= 1'b0;
                        r_maxbin <= r_run_bin;
                        r_maxpwr <= r_run_pwr;
                        if (w_pass) begin
                            r_detectdone <= 1'b1;
                            r_rdaddr1    <= r_run_bin;
                            r_state      <= ST_COMPLETE;
                        end else begin
                            r_miss    <= 1'b1;
                            r_rdaddr1 <= '0;
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdaddr1    = r_rdaddr1;
    assign bus.maxbin     = r_maxbin;
    assign bus.maxpwr     = r_maxpwr;
    assign bus.detectdone = r_detectdone;
    assign bus.miss       = r_miss;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_peak_bin_finder.sv
// Directed bench for peak_bin_finder. Three instances share one RAM image,
// fftdone and reset: dut0 default, dut1 with RD_LAT=2, dut2 with PWR_MIN=1.
module tb_peak_bin_finder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fftdone = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [27:0] mem [1024];

    peak_bin_finder_if b0 ();
    peak_bin_finder_if b1 ();
    peak_bin_finder_if b2 ();

    peak_bin_finder #(.RD_LAT(1)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    peak_bin_finder #(.RD_LAT(2)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    peak_bin_finder #(.RD_LAT(1), .PWR_MIN(1)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

    // RAM models with one or two cycles of read latency.
    logic [27:0] q0, q1a, q1b, q2;
    always @(posedge clk) begin
        q0  <= mem[b0.rdaddr1];
        q1a <= mem[b1.rdaddr1];
        q1b <= q1a;
        q2  <= mem[b2.rdaddr1];
    end

    assign b0.ramq1 = q0;
    assign b1.ramq1 = q1b;
    assign b2.ramq1 = q2;
    assign b0.fftdone = fftdone;
    assign b1.fftdone = fftdone;
    assign b2.fftdone = fftdone;

    logic        o_det  [3];
    logic        o_miss [3];
    logic        o_busy [3];
    logic [9:0]  o_addr [3];
    logic [9:0]  o_bin  [3];
    logic [27:0] o_pwr  [3];

    assign o_det[0] = b0.detectdone;  assign o_det[1] = b1.detectdone;  assign o_det[2] = b2.detectdone;
    assign o_miss[0] = b0.miss;       assign o_miss[1] = b1.miss;       assign o_miss[2] = b2.miss;
    assign o_busy[0] = b0.busy;       assign o_busy[1] = b1.busy;       assign o_busy[2] = b2.busy;
    assign o_addr[0] = b0.rdaddr1;    assign o_addr[1] = b1.rdaddr1;    assign o_addr[2] = b2.rdaddr1;
    assign o_bin[0] = b0.maxbin;      assign o_bin[1] = b1.maxbin;      assign o_bin[2] = b2.maxbin;
    assign o_pwr[0] = b0.maxpwr;      assign o_pwr[1] = b1.maxpwr;      assign o_pwr[2] = b2.maxpwr;

    // Observations collected during one scan window.
    int det_at [3];
    int miss_at [3];
    int det_cnt [3];
    int miss_cnt [3];
    int both_cnt;
    logic        busy1;
    logic [9:0]  mid_bin;
    logic [27:0] mid_pwr;
    logic [9:0]  rst_addr, rst_bin;
    logic [27:0] rst_pwr;
    logic        rst_busy;

    function automatic logic [27:0] cw(input int re, input int im);
        logic [13:0] r;
        logic [13:0] i;
        r = re[13:0];
        i = im[13:0];
        return {r, i};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 28'd0;
    endtask

    // Pulse fftdone for one cycle; the next posedge is cycle 0.
    task automatic start_scan();
        @(posedge clk); #1;
        fftdone = 1'b1;
        @(posedge clk); #1;
        fftdone = 1'b0;
    endtask

    // Watch ncyc cycles after the start edge. Optionally pulse fftdone or
    // reset after cycle fd_at / rst_at (-1 disables).
    task automatic observe(input int ncyc, input int fd_at, input int rst_at);
        for (int d = 0; d < 3; d++) begin
            det_at[d] = -1; miss_at[d] = -1; det_cnt[d] = 0; miss_cnt[d] = 0;
        end
        both_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (o_det[d]) begin det_cnt[d]++; if (det_at[d] < 0) det_at[d] = c; end
                if (o_miss[d]) begin miss_cnt[d]++; if (miss_at[d] < 0) miss_at[d] = c; end
                if (o_det[d] && o_miss[d]) both_cnt++;
            end
            if (c == 1) busy1 = o_busy[0];
            if (c == 300) begin mid_bin = o_bin[0]; mid_pwr = o_pwr[0]; end
            if (c == rst_at + 1) begin
                rst_addr = o_addr[0]; rst_bin = o_bin[0]; rst_pwr = o_pwr[0]; rst_busy = o_busy[0];
            end
            fftdone = (c == fd_at);
            reset   = (c == rst_at);
        end
        fftdone = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({o_addr[d], o_bin[d], o_pwr[d], o_det[d], o_miss[d], o_busy[d]} !== 51'd0) begin
                errors++;
                $display("FAIL reset dut%0d: addr=%0d bin=%0d pwr=%0d det=%0b miss=%0b busy=%0b required all 0",
                         d, o_addr[d], o_bin[d], o_pwr[d], o_det[d], o_miss[d], o_busy[d]);
            end
        end
        $display("reset: outputs checked after reset release");
    endtask

    task automatic test_single_tone();
        int exp_at [3] = '{514, 515, 514};
        clear_mem();
        mem[100] = cw(1000, -500);
        start_scan();
        observe(600, -1, -1);
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL tone_busy: got %0b required 1", busy1); end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (det_at[d] !== exp_at[d] || det_cnt[d] !== 1 || miss_cnt[d] !== 0) begin
                errors++;
                $display("FAIL tone_timing dut%0d: det_at=%0d det_cnt=%0d miss_cnt=%0d required %0d/1/0",
                         d, det_at[d], det_cnt[d], miss_cnt[d], exp_at[d]);
            end
            checks++;
            if (o_bin[d] !== 10'd100 || o_pwr[d] !== 28'd1250000) begin
                errors++;
                $display("FAIL tone_result dut%0d: bin=%0d pwr=%0d required 100/1250000", d, o_bin[d], o_pwr[d]);
            end
            checks++;
            if (o_addr[d] !== 10'd100 || o_busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL tone_hold dut%0d: addr=%0d busy=%0b required 100/0", d, o_addr[d], o_busy[d]);
            end
        end
        $display("single_tone: dut0 det_at=%0d bin=%0d pwr=%0d", det_at[0], o_bin[0], o_pwr[0]);
    endtask

    task automatic test_tie_range();
        clear_mem();
        mem[40]  = cw(300, 400);
        mem[300] = cw(300, 400);
        mem[600] = cw(8191, 0);
        start_scan();
        observe(600, -1, -1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_bin[d] !== 10'd40 || o_pwr[d] !== 28'd250000 || det_cnt[d] !== 1) begin
                errors++;
                $display("FAIL tie_range dut%0d: bin=%0d pwr=%0d det_cnt=%0d required 40/250000/1",
                         d, o_bin[d], o_pwr[d], det_cnt[d]);
            end
        end
        $display("tie_range: dut0 bin=%0d pwr=%0d", o_bin[0], o_pwr[0]);
    endtask

    task automatic test_extreme();
        clear_mem();
        mem[7] = cw(-8192, -8192);
        mem[8] = cw(8191, 8191);
        start_scan();
        observe(600, -1, -1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_bin[d] !== 10'd7 || o_pwr[d] !== 28'd134217728) begin
                errors++;
                $display("FAIL extreme dut%0d: bin=%0d pwr=%0d required 7/134217728", d, o_bin[d], o_pwr[d]);
            end
        end
        $display("extreme: dut0 bin=%0d pwr=%0d", o_bin[0], o_pwr[0]);
    endtask

    task automatic test_threshold_miss();
        clear_mem();
        start_scan();
        observe(600, -1, -1);
        checks++;
        if (miss_at[2] !== 514 || miss_cnt[2] !== 1 || det_cnt[2] !== 0) begin
            errors++;
            $display("FAIL miss_pulse dut2: miss_at=%0d miss_cnt=%0d det_cnt=%0d required 514/1/0",
                     miss_at[2], miss_cnt[2], det_cnt[2]);
        end
        checks++;
        if (o_bin[2] !== 10'd1 || o_pwr[2] !== 28'd0 || o_addr[2] !== 10'd0 || o_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL miss_state dut2: bin=%0d pwr=%0d addr=%0d busy=%0b required 1/0/0/0",
                     o_bin[2], o_pwr[2], o_addr[2], o_busy[2]);
        end
        checks++;
        if (det_cnt[0] !== 1 || miss_cnt[0] !== 0 || o_bin[0] !== 10'd1 || o_pwr[0] !== 28'd0 || o_addr[0] !== 10'd1) begin
            errors++;
            $display("FAIL zero_spectrum dut0: det_cnt=%0d miss_cnt=%0d bin=%0d pwr=%0d addr=%0d required 1/0/1/0/1",
                     det_cnt[0], miss_cnt[0], o_bin[0], o_pwr[0], o_addr[0]);
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL det_and_miss: got %0d overlapping cycles required 0", both_cnt);
        end
        $display("threshold_miss: dut2 miss_at=%0d bin=%0d pwr=%0d", miss_at[2], o_bin[2], o_pwr[2]);
    endtask

    task automatic test_restart_ignore();
        int exp_at [3] = '{514, 515, 514};
        clear_mem();
        mem[100] = cw(1000, -500);
        start_scan();
        observe(600, 200, -1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (det_at[d] !== exp_at[d] || det_cnt[d] !== 1 || o_busy[d] !== 1'b0 || o_bin[d] !== 10'd100) begin
                errors++;
                $display("FAIL restart_ignore dut%0d: det_at=%0d det_cnt=%0d busy=%0b bin=%0d required %0d/1/0/100",
                         d, det_at[d], det_cnt[d], o_busy[d], o_bin[d], exp_at[d]);
            end
        end
        $display("restart_ignore: dut0 det_at=%0d", det_at[0]);
    endtask

    task automatic test_complete_restart();
        clear_mem();
        mem[250] = cw(50, 60);
        start_scan();
        observe(600, -1, -1);
        checks++;
        if (mid_bin !== 10'd100 || mid_pwr !== 28'd1250000) begin
            errors++;
            $display("FAIL outputs_held_mid_scan: bin=%0d pwr=%0d required 100/1250000", mid_bin, mid_pwr);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_bin[d] !== 10'd250 || o_pwr[d] !== 28'd6100 || det_cnt[d] !== 1) begin
                errors++;
                $display("FAIL complete_restart dut%0d: bin=%0d pwr=%0d det_cnt=%0d required 250/6100/1",
                         d, o_bin[d], o_pwr[d], det_cnt[d]);
            end
        end
        checks++;
        if (det_at[0] !== 514) begin
            errors++;
            $display("FAIL complete_restart_latency: got %0d required 514", det_at[0]);
        end
        $display("complete_restart: dut0 bin=%0d det_at=%0d", o_bin[0], det_at[0]);
    endtask

    task automatic test_reset_mid();
        start_scan();
        observe(600, -1, 300);
        checks++;
        if (rst_addr !== 10'd0 || rst_bin !== 10'd0 || rst_pwr !== 28'd0 || rst_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: addr=%0d bin=%0d pwr=%0d busy=%0b required 0/0/0/0",
                     rst_addr, rst_bin, rst_pwr, rst_busy);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (det_cnt[d] !== 0 || miss_cnt[d] !== 0) begin
                errors++;
                $display("FAIL reset_mid_no_pulse dut%0d: det_cnt=%0d miss_cnt=%0d required 0/0",
                         d, det_cnt[d], miss_cnt[d]);
            end
        end
        start_scan();
        observe(600, -1, -1);
        checks++;
        if (det_at[0] !== 514 || o_bin[0] !== 10'd250 || o_pwr[0] !== 28'd6100) begin
            errors++;
            $display("FAIL reset_mid_rescan: det_at=%0d bin=%0d pwr=%0d required 514/250/6100",
                     det_at[0], o_bin[0], o_pwr[0]);
        end
        $display("reset_mid: rescan dut0 det_at=%0d bin=%0d", det_at[0], o_bin[0]);
    endtask

    task automatic test_rdlat2_edge();
        int exp_at [3] = '{514, 515, 514};
        clear_mem();
        mem[0]   = cw(8191, 8191);
        mem[512] = cw(8191, 8191);
        mem[511] = cw(100, 0);
        start_scan();
        observe(600, -1, -1);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (det_at[d] !== exp_at[d] || o_bin[d] !== 10'd511 || o_pwr[d] !== 28'd10000 || o_addr[d] !== 10'd511) begin
                errors++;
                $display("FAIL edge_bin dut%0d: det_at=%0d bin=%0d pwr=%0d addr=%0d required %0d/511/10000/511",
                         d, det_at[d], o_bin[d], o_pwr[d], o_addr[d], exp_at[d]);
            end
        end
        $display("rdlat2_edge: dut1 det_at=%0d bin=%0d", det_at[1], o_bin[1]);
    endtask

    initial begin
        clear_mem();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single_tone();
        test_tie_range();
        test_extreme();
        test_threshold_miss();
        test_restart_ignore();
        test_complete_restart();
        test_reset_mid();
        test_rdlat2_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
